// File: rtl/writeback_unit_if.sv
// Bus bundle between the ALU/load result producers, decode hazard lookup and
// the writeback unit. The unit itself connects through the slave modport.
//
// Handshake: a source transfers on a rising clock edge where its valid and
// ready are both high; valid must not wait on ready, and ready may depend on
// the same-cycle mem_valid (alu_ready does) but never on alu_valid.
interface writeback_unit_if #(
  parameter int word_length = 32
);
  logic                   alu_valid;
  logic                   alu_ready;
  logic [4:0]             alu_address;
  logic [word_length-1:0] alu_data;

  logic                   mem_valid;
  logic                   mem_ready;
  logic [4:0]             mem_address;
  logic [word_length-1:0] mem_data;

  logic                   write_enable;
  logic [4:0]             write_address;
  logic [word_length-1:0] data_in;

  logic [4:0]             read1_address;
  logic [4:0]             read2_address;
  logic                   read1_pending;
  logic                   read2_pending;

  modport master (
    output alu_valid, alu_address, alu_data,
    output mem_valid, mem_address, mem_data,
    output read1_address, read2_address,
    input  alu_ready, mem_ready,
    input  write_enable, write_address, data_in,
    input  read1_pending, read2_pending
  );

  modport slave (
    input  alu_valid, alu_address, alu_data,
    input  mem_valid, mem_address, mem_data,
    input  read1_address, read2_address,
    output alu_ready, mem_ready,
    output write_enable, write_address, data_in,
    output read1_pending, read2_pending
  );
endinterface

// File: rtl/writeback_unit.sv
// Merges ALU and load results into a small in-order queue and retires one
// register-file write every three cycles, with hazard lookup for decode.
module writeback_unit #(
  parameter int word_length = 32,
  parameter int queue_depth = 4
) (
  input  logic                           clock,
  input  logic                           reset_n,
  writeback_unit_if.slave                bus,
  output logic [1:0]                     dbg_state,
  output logic [$clog2(queue_depth):0]   dbg_count
);
  localparam int ptr_w = $clog2(queue_depth);
  localparam int cnt_w = ptr_w + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic                   write_enable_next;
  logic                   pop;

  logic [4:0]             q_addr [queue_depth];
  logic [word_length-1:0] q_data [queue_depth];
  logic [ptr_w-1:0]       wr_ptr, rd_ptr;
  logic [cnt_w-1:0]       count;
  logic [cnt_w-1:0]       ready_count;
  logic [cnt_w-1:0]       free;

  logic                   mem_fire, alu_fire;
  logic                   mem_push, alu_push;
  logic [ptr_w-1:0]       alu_slot;
  logic [queue_depth-1:0] entry_valid;
  logic                   in_flight;
  logic                   match1, match2;

  // Readiness is judged on registered occupancy only; a pop this cycle does
  // not free a slot until the next. While reset is held the queue is empty.
  assign ready_count   = reset_n ? count : '0;
  assign free          = cnt_w'(queue_depth) - ready_count;
  assign bus.mem_ready = (free >= cnt_w'(1));
  assign bus.alu_ready = (free >= cnt_w'(2)) || ((free == cnt_w'(1)) && !bus.mem_valid);

  assign mem_fire = bus.mem_valid && bus.mem_ready;
  assign alu_fire = bus.alu_valid && bus.alu_ready;
  assign mem_push = mem_fire && (bus.mem_address != 5'd0);
  assign alu_push = alu_fire && (bus.alu_address != 5'd0);
  assign alu_slot = wr_ptr + ptr_w'(mem_push);

  always_comb begin
    state_next        = state;
    pop               = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP:   state_next = STROBE;
      STROBE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    write_enable_next = (state_next == STROBE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state             <= IDLE;
      bus.write_enable  <= 1'b0;
      bus.write_address <= '0;
      bus.data_in       <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
    end else begin
      state            <= state_next;
      bus.write_enable <= write_enable_next;
      if (pop) begin
        bus.write_address <= q_addr[rd_ptr];
        bus.data_in       <= q_data[rd_ptr];
        rd_ptr            <= rd_ptr + ptr_w'(1);
      end
      wr_ptr <= wr_ptr + ptr_w'(mem_push) + ptr_w'(alu_push);
      count  <= count + cnt_w'(mem_push) + cnt_w'(alu_push) - cnt_w'(pop);
    end
  end

  // Mem lands first so a same-cycle pair to one register retires mem then alu.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (mem_push) begin
        q_addr[wr_ptr] <= bus.mem_address;
        q_data[wr_ptr] <= bus.mem_data;
      end
      if (alu_push) begin
        q_addr[alu_slot] <= bus.alu_address;
        q_data[alu_slot] <= bus.alu_data;
      end
    end
  end

  always_comb begin
    logic [ptr_w-1:0] rel;
    rel         = '0;
    entry_valid = '0;
    for (int i = 0; i < queue_depth; i++) begin
      rel            = ptr_w'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, rel} < count);
    end
  end

  assign in_flight = (state == SETUP) || (state == STROBE);

  always_comb begin
    match1 = in_flight && (bus.write_address == bus.read1_address);
    match2 = in_flight && (bus.write_address == bus.read2_address);
    for (int i = 0; i < queue_depth; i++) begin
      if (entry_valid[i] && (q_addr[i] == bus.read1_address)) match1 = 1'b1;
      if (entry_valid[i] && (q_addr[i] == bus.read2_address)) match2 = 1'b1;
    end
  end

  assign bus.read1_pending = (bus.read1_address != 5'd0) && match1;
  assign bus.read2_pending = (bus.read2_address != 5'd0) && match2;

  assign dbg_state = state;
  assign dbg_count = count;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: a per-cycle vector table followed by
// hand-written drain and pointer-wrap sequences checked against a retire queue.
module tb_writeback_unit;
  logic       clock;
  logic       reset_n;
  logic [1:0] dbg_state;
  logic [2:0] dbg_count;

  writeback_unit_if #(.word_length(32)) bus();

  writeback_unit #(.word_length(32), .queue_depth(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst_n;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        ar;
    logic        mr;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] di;
    logic        p1;
    logic        p2;
    logic [2:0]  cnt;
    logic [1:0]  st;
  } vec_t;

  vec_t        vq[$];
  logic [36:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_ret = 0;
  logic        mon_en = 1'b0;

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic row(input logic rst_n, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                     input logic mv, input logic [4:0] ma, input logic [31:0] md,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic ar, input logic mr, input logic we, input logic [4:0] wa,
                     input logic [31:0] di, input logic p1, input logic p2,
                     input logic [2:0] cnt, input logic [1:0] st);
    vec_t v;
    v.rst_n = rst_n; v.av = av; v.aa = aa; v.ad = ad;
    v.mv = mv; v.ma = ma; v.md = md; v.r1 = r1; v.r2 = r2;
    v.ar = ar; v.mr = mr; v.we = we; v.wa = wa; v.di = di;
    v.p1 = p1; v.p2 = p2; v.cnt = cnt; v.st = st;
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_address = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_address = '0; bus.mem_data = '0;
    bus.read1_address = '0; bus.read2_address = '0;
  endtask

  // driver: offer one ALU result and hold it until accepted
  task automatic send_alu(input logic [4:0] a, input logic [31:0] d);
    int waited;
    waited = 0;
    @(negedge clock);
    bus.alu_valid = 1'b1; bus.alu_address = a; bus.alu_data = d;
    #1;
    while (!bus.alu_ready && waited < 50) begin
      @(negedge clock);
      #1;
      waited++;
    end
    check("send_timeout", n_ret, 64'(bus.alu_ready), 64'(1));
    if (bus.alu_ready && a != 5'd0) exp_q.push_back({a, d});
    @(posedge clock);
    #1;
    bus.alu_valid = 1'b0;
  endtask

  // scoreboard: every strobe must match the oldest expected write
  always @(negedge clock) begin
    if (mon_en && bus.write_enable) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", n_ret, 64'(bus.write_enable), 64'(0));
      end else begin
        check("retire", n_ret, 64'({bus.write_address, bus.data_in}), 64'(exp_q.pop_front()));
      end
      n_ret++;
    end
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock);
    check(name, 0, 64'(exp_q.size()), 64'(0));
    repeat (6) @(negedge clock);
  endtask

  initial begin
    logic [4:0] wrap_addr [10];
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);

    // rst av aa ad  mv ma md  r1 r2 | ar mr we wa di  p1 p2 cnt st
    row(0, 0,0,0, 0,0,0, 0,0,  1,1,0,0,0, 0,0,0,0);
    // single write to r5
    row(1, 1,5,'hDEADBEEF, 0,0,0, 5,0,  1,1,0,0,0, 0,0,0,0);
    row(1, 0,0,0, 0,0,0, 5,0,  1,1,0,0,0, 1,0,1,0);
    row(1, 0,0,0, 0,0,0, 5,0,  1,1,0,5,'hDEADBEEF, 1,0,0,1);
    row(1, 0,0,0, 0,0,0, 5,0,  1,1,1,5,'hDEADBEEF, 1,0,0,2);
    row(1, 0,0,0, 0,0,0, 5,0,  1,1,0,5,'hDEADBEEF, 0,0,0,0);
    // dual source to r3: mem retires before alu
    row(1, 1,3,'h22, 1,3,'h11, 3,7,  1,1,0,5,'hDEADBEEF, 0,0,0,0);
    row(1, 0,0,0, 0,0,0, 3,7,  1,1,0,5,'hDEADBEEF, 1,0,2,0);
    row(1, 0,0,0, 0,0,0, 3,7,  1,1,0,3,'h11, 1,0,1,1);
    row(1, 0,0,0, 0,0,0, 3,7,  1,1,1,3,'h11, 1,0,1,2);
    row(1, 0,0,0, 0,0,0, 3,7,  1,1,0,3,'h11, 1,0,1,0);
    row(1, 0,0,0, 0,0,0, 3,7,  1,1,0,3,'h22, 1,0,0,1);
    row(1, 0,0,0, 0,0,0, 3,7,  1,1,1,3,'h22, 1,0,0,2);
    row(1, 0,0,0, 0,0,0, 3,7,  1,1,0,3,'h22, 0,0,0,0);
    // zero register from both sources: accepted, never written
    row(1, 1,0,'hFFFFFFFF, 1,0,'h12345678, 0,0,  1,1,0,3,'h22, 0,0,0,0);
    row(1, 0,0,0, 0,0,0, 0,0,  1,1,0,3,'h22, 0,0,0,0);
    row(1, 0,0,0, 0,0,0, 0,0,  1,1,0,3,'h22, 0,0,0,0);
    // hazard on r7 through the load path
    row(1, 0,0,0, 1,7,'h77, 0,7,  1,1,0,3,'h22, 0,0,0,0);
    row(1, 0,0,0, 0,0,0, 0,7,  1,1,0,3,'h22, 0,1,1,0);
    row(1, 0,0,0, 0,0,0, 0,7,  1,1,0,7,'h77, 0,1,0,1);
    row(1, 0,0,0, 0,0,0, 0,7,  1,1,1,7,'h77, 0,1,0,2);
    row(1, 0,0,0, 0,0,0, 0,7,  1,1,0,7,'h77, 0,0,0,0);
    // reset during SETUP with two entries queued
    row(1, 1,9,'hC9, 1,8,'hC8, 0,0,  1,1,0,7,'h77, 0,0,0,0);
    row(1, 1,10,'hCA, 0,0,0, 9,0,  1,1,0,7,'h77, 1,0,2,0);
    row(0, 1,11,'hCB, 1,12,'hCC, 9,10,  1,1,0,8,'hC8, 1,1,2,1);
    row(1, 0,0,0, 0,0,0, 9,10,  1,1,0,0,0, 0,0,0,0);
    row(1, 0,0,0, 0,0,0, 9,10,  1,1,0,0,0, 0,0,0,0);
    row(1, 0,0,0, 0,0,0, 9,10,  1,1,0,0,0, 0,0,0,0);
    row(1, 0,0,0, 0,0,0, 9,10,  1,1,0,0,0, 0,0,0,0);
    // fill while the FSM is busy: alu_ready drops at count 3 with mem_valid, and at 4
    row(1, 1,2,'hA2, 1,1,'hA1, 0,0,  1,1,0,0,0, 0,0,0,0);
    row(1, 1,4,'hA4, 1,3,'hA3, 0,0,  1,1,0,0,0, 0,0,2,0);
    row(1, 1,6,'hA6, 1,5,'hA5, 0,0,  0,1,0,1,'hA1, 0,0,3,1);
    row(1, 1,6,'hA6, 0,0,0, 0,0,  0,0,1,1,'hA1, 0,0,4,2);
    row(1, 1,6,'hA6, 0,0,0, 0,0,  0,0,0,1,'hA1, 0,0,4,0);
    row(1, 1,6,'hA6, 0,0,0, 0,0,  1,1,0,2,'hA2, 0,0,3,1);
    row(1, 0,0,0, 0,0,0, 0,0,  0,0,1,2,'hA2, 0,0,4,2);
    row(1, 0,0,0, 0,0,0, 0,0,  0,0,0,2,'hA2, 0,0,4,0);

    // what the fill left behind must retire in order
    exp_q.push_back({5'd3, 32'hA3});
    exp_q.push_back({5'd4, 32'hA4});
    exp_q.push_back({5'd5, 32'hA5});
    exp_q.push_back({5'd6, 32'hA6});

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clock);
      reset_n           = vq[i].rst_n;
      bus.alu_valid     = vq[i].av;
      bus.alu_address   = vq[i].aa;
      bus.alu_data      = vq[i].ad;
      bus.mem_valid     = vq[i].mv;
      bus.mem_address   = vq[i].ma;
      bus.mem_data      = vq[i].md;
      bus.read1_address = vq[i].r1;
      bus.read2_address = vq[i].r2;
      #1;
      check("alu_ready",     i, 64'(bus.alu_ready),     64'(vq[i].ar));
      check("mem_ready",     i, 64'(bus.mem_ready),     64'(vq[i].mr));
      check("write_enable",  i, 64'(bus.write_enable),  64'(vq[i].we));
      check("write_address", i, 64'(bus.write_address), 64'(vq[i].wa));
      check("data_in",       i, 64'(bus.data_in),       64'(vq[i].di));
      check("read1_pending", i, 64'(bus.read1_pending), 64'(vq[i].p1));
      check("read2_pending", i, 64'(bus.read2_pending), 64'(vq[i].p2));
      check("count",         i, 64'(dbg_count),         64'(vq[i].cnt));
      check("state",         i, 64'(dbg_state),         64'(vq[i].st));
    end
    idle_inputs();
    mon_en = 1'b1;
    wait_drain("fill_drain");

    // ten writes through the ALU port: pointer wrap, repeated registers, r0
    wrap_addr = '{5'd7, 5'd7, 5'd3, 5'd0, 5'd12, 5'd31, 5'd7, 5'd20, 5'd3, 5'd15};
    for (int i = 0; i < 10; i++) send_alu(wrap_addr[i], 32'h1000 + 32'(i));
    wait_drain("wrap_drain");
    check("final_count", 0, 64'(dbg_count), 64'(0));
    check("final_state", 0, 64'(dbg_state), 64'(0));
    check("retire_total", 0, 64'(n_ret), 64'(13));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter word_length, default 32: width of every data word.
REQ-002 Parameter queue_depth, default 4: number of entries in the pending-write queue; SHALL be a power of two, at least 2.
REQ-003 Port clock  input  1: single clock; all state changes on its rising edge.
REQ-004 Port reset_n  input  1: reset is synchronous and active-low.
REQ-005 Port alu_valid / alu_ready  input / output  1 / 1: ALU result handshake.
REQ-006 Port alu_address / alu_data  input  5 / word_length: ALU destination register and result.
REQ-007 Port mem_valid / mem_ready  input / output  1 / 1: load result handshake.
REQ-008 Port mem_address / mem_data  input  5 / word_length: load destination register and data.
REQ-009 Port write_enable  output  1: register-file write strobe; the register file writes on its rising edge.
REQ-010 Port write_address / data_in  output  5 / word_length: register-file write address and data.
REQ-011 Port read1_address / read2_address  input  5: decode-stage source registers.
REQ-012 Port read1_pending / read2_pending  output  1: source register has an unretired write.

Function
REQ-013 A transfer SHALL occur on a source when its valid and ready are both high at a rising clock edge.
REQ-014 Transfers SHALL be enqueued into a FIFO of queue_depth entries, each holding {address, data}.
REQ-015 Same-cycle transfers from both sources SHALL enqueue the mem entry first, then the alu entry.
REQ-016 Transfers with address 0 SHALL be accepted but not enqueued.
REQ-017 Let free = queue_depth - count, with count the registered occupancy. No same-cycle pop bypass.
REQ-018 mem_ready SHALL be high iff free >= 1.
REQ-019 alu_ready SHALL be high iff free >= 2, or free == 1 and mem_valid is low.
REQ-020 The write FSM SHALL have states IDLE, SETUP and STROBE.
REQ-021 IDLE with a non-empty queue: pop the head, load write_address and data_in from it, and go to SETUP. Otherwise stay in IDLE.
REQ-022 SETUP: write_enable stays 0 and the FSM goes to STROBE.
REQ-023 STROBE: write_enable is 1 for exactly this cycle, then the FSM goes to IDLE.
REQ-024 write_address and data_in SHALL be held stable from SETUP through the IDLE cycle after STROBE. Outputs change only when an entry is popped.
REQ-025 Throughput SHALL be one register write per 3 cycles. Latency from an enqueue into an empty idle unit to the write_enable rise SHALL be 3 edges (pop, SETUP, STROBE).
REQ-026 write_enable SHALL be driven directly from a flip-flop (glitch-free).
REQ-027 readN_pending SHALL be combinational and high iff readN_address != 0 and matches either a valid queue entry's address or the in-flight address (state SETUP or STROBE).
REQ-028 An enqueue and a pop in the same cycle SHALL leave count unchanged; the FIFO pointers SHALL wrap modulo queue_depth.
REQ-029 Two writes to one register SHALL retire in enqueue order.

Reset
REQ-030 With reset_n low at a clock edge: FSM goes to IDLE, count=0, pointers=0, write_enable=0, write_address=0, data_in=0.
REQ-031 Reset SHALL take priority over any handshake on the same edge. Entries queued or in flight are discarded; no write_enable pulse follows.
REQ-032 During reset, alu_ready and mem_ready SHALL follow REQ-018/019 with count=0. Transfers on the reset edge are dropped.

Verification
REQ-033 Single write: alu_valid=1, alu_address=5, alu_data=0xDEADBEEF, for one cycle. Required: write_enable rises 3 edges later with write_address=5, data_in=0xDEADBEEF, and it is high for 1 cycle.
REQ-034 Dual source: mem(3, 0x11) and alu(3, 0x22) in the same cycle. Required: the mem write retires first, then the alu write (final r3=0x22); the two strobes are 3 cycles apart.
REQ-035 Fill: 4 alu transfers with the FSM stalled in SETUP/STROBE. Required: alu_ready=0 when count=3 and mem_valid=1, or when count=4; no entry lost; pointer wrap exercised over 10 writes.
REQ-036 Zero register: alu_address=0 accepted. Required: no write_enable pulse, and read1_pending=0 for read1_address=0.
REQ-037 Hazard: enqueue r7. Required: read2_pending=1 for read2_address=7 until the cycle after STROBE, then 0.
REQ-038 Mid-operation reset: reset_n low during SETUP with 2 entries queued. Required: write_enable stays 0, count=0, write_address=0, and no pulse afterward.
